// File: rtl/logic_gate_decoder.sv
// Receive-side checker for 7-bit logic-gate vectors: recovers (a, b), flags illegal
// encodings, buffers results in a small FIFO and tracks errors with an optional halt.
module logic_gate_decoder #(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter int HALT_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       gv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr,
  output logic             halted
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [2:0]  mem [DEPTH];
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        dec_a;
  logic        dec_b;
  logic        dec_err;
  logic [2:0]  head;

  function automatic logic [6:0] canon(input logic a, input logic b);
    return {~a, a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
  endfunction

  assign dec_a   = ~gv[6];
  assign dec_b   = dec_a ? gv[5] : gv[4];
  assign dec_err = (gv != canon(dec_a, dec_b));

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = (state == RUN) && !full;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign halted    = (state == HALT);

  // Gate the head with empty so a reset FIFO shows zeros regardless of stale storage.
  assign head = empty ? 3'b000 : mem[rd_ptr[AW-1:0]];
  assign {out_a, out_b, out_err} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {dec_a, dec_b, dec_err};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // clr outranks a same-cycle error; the errored entry itself is still pushed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr) begin
      state      <= RUN;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (push && dec_err) begin
      err_sticky <= 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + 1'b1;
      end
      if (HALT_ON_ERR != 0) begin
        state <= HALT;
      end
    end
  end

endmodule

// File: tb/tb_logic_gate_decoder.sv
// Randomized self-checking bench for logic_gate_decoder against a queue-based
// reference model; a second instance covers counter saturation without halting.
module tb_logic_gate_decoder;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] gv;
  logic       out_valid;
  logic       out_ready;
  logic       out_a;
  logic       out_b;
  logic       out_err;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       clr;
  logic       halted;

  logic       s_in_valid;
  logic       s_in_ready;
  logic [6:0] s_gv;
  logic       s_out_valid;
  logic       s_out_ready;
  logic       s_out_a;
  logic       s_out_b;
  logic       s_out_err;
  logic       s_err_sticky;
  logic [1:0] s_err_cnt;
  logic       s_clr;
  logic       s_halted;

  int total;
  int bad;

  logic [6:0] legal [4];
  logic [2:0] q [$];
  int         m_cnt;
  logic       m_sticky;
  logic       m_halted;

  logic_gate_decoder #(.DEPTH(DEPTH), .CNT_W(8), .HALT_ON_ERR(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .gv(gv),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_err(out_err), .err_sticky(err_sticky), .err_cnt(err_cnt), .clr(clr),
    .halted(halted)
  );

  logic_gate_decoder #(.DEPTH(DEPTH), .CNT_W(2), .HALT_ON_ERR(0)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .gv(s_gv),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_a(s_out_a), .out_b(s_out_b),
    .out_err(s_out_err), .err_sticky(s_err_sticky), .err_cnt(s_err_cnt), .clr(s_clr),
    .halted(s_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Decode from the rules: a = ~not-bit, b from and/or; legal iff it equals the table entry.
  function automatic logic [2:0] model_decode(input logic [6:0] v);
    logic a;
    logic b;
    a = ~v[6];
    b = a ? v[5] : v[4];
    return {a, b, (v != legal[{a, b}])};
  endfunction

  function automatic logic [3:0] exp_head();
    return (q.size() > 0) ? {1'b1, q[0]} : 4'b0000;
  endfunction

  function automatic logic model_ready();
    return !m_halted && (q.size() < DEPTH);
  endfunction

  function automatic logic [6:0] rand_legal();
    return legal[$urandom_range(0, 3)];
  endfunction

  task automatic model_reset();
    q.delete();
    m_cnt    = 0;
    m_sticky = 1'b0;
    m_halted = 1'b0;
  endtask

  // Advance one clock on the main DUT and step the model with the inputs seen at that edge.
  task automatic tick();
    logic       acc;
    logic       pp;
    logic [2:0] ent;
    acc = in_valid && model_ready();
    pp  = (q.size() > 0) && out_ready;
    ent = model_decode(gv);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(ent);
    if (clr) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
      m_halted = 1'b0;
    end else if (acc && ent[0]) begin
      m_sticky = 1'b1;
      if (m_cnt < 255) m_cnt++;
      m_halted = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr       = 1'b0;
    repeat (DEPTH + 2) tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL drain_empty: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, out_valid, out_a, out_b, out_err} !== 5'b10000) begin
      bad++;
      $display("[TB] FAIL reset_io: got %b expected 10000",
               {in_ready, out_valid, out_a, out_b, out_err});
    end
    total++;
    if ({err_sticky, err_cnt, halted} !== 10'b0) begin
      bad++;
      $display("[TB] FAIL reset_err: sticky=%b cnt=%0d halted=%b expected 0/0/0",
               err_sticky, err_cnt, halted);
    end
  endtask

  task automatic test_legal_sweep();
    logic [3:0] want [4];
    want = '{4'b1000, 4'b1010, 4'b1100, 4'b1110};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      gv       = legal[i];
      tick();
      total++;
      if ({out_valid, out_a, out_b, out_err} !== want[i]) begin
        bad++;
        $display("[TB] FAIL sweep_%0d: got %b expected %b", i,
                 {out_valid, out_a, out_b, out_err}, want[i]);
      end
      total++;
      if (err_cnt !== 8'd0) begin
        bad++;
        $display("[TB] FAIL sweep_cnt_%0d: err_cnt=%0d expected 0", i, err_cnt);
      end
    end
    drain();
  endtask

  task automatic test_illegal_halt();
    in_valid  = 1'b1;
    gv        = 7'h00;
    out_ready = 1'b0;
    tick();
    total++;
    if ({out_valid, out_a, out_b, out_err} !== 4'b1101) begin
      bad++;
      $display("[TB] FAIL halt_head: got %b expected 1101", {out_valid, out_a, out_b, out_err});
    end
    total++;
    if ({err_cnt, err_sticky, halted, in_ready} !== {8'd1, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL halt_state: cnt=%0d sticky=%b halted=%b in_ready=%b expected 1/1/1/0",
               err_cnt, err_sticky, halted, in_ready);
    end
    gv        = 7'h4D;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      bad++;
      $display("[TB] FAIL halt_block: out_valid=%b expected 0 (4D must not be accepted)", out_valid);
    end
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if ({halted, err_cnt, err_sticky, in_ready} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL clr_release: halted=%b cnt=%0d sticky=%b in_ready=%b expected 0/0/0/1",
               halted, err_cnt, err_sticky, in_ready);
    end
    in_valid = 1'b1;
    gv       = 7'h4D;
    tick();
    total++;
    if ({out_valid, out_a, out_b, out_err} !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL clr_accept: got %b expected 1000", {out_valid, out_a, out_b, out_err});
    end
    drain();
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted  = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      gv       = rand_legal();
      total++;
      if (in_ready !== model_ready()) begin
        bad++;
        $display("[TB] FAIL bp_ready_%0d: in_ready=%b expected %b", i, in_ready, model_ready());
      end
      if (in_ready === 1'b1) accepted++;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (accepted != 4 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_full: accepted=%0d in_ready=%b expected 4/0", accepted, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({out_valid, out_a, out_b, out_err} !== exp_head()) begin
        bad++;
        $display("[TB] FAIL bp_drain_%0d: got %b expected %b", i,
                 {out_valid, out_a, out_b, out_err}, exp_head());
      end
      tick();
      if (i == 0) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("[TB] FAIL bp_reopen: in_ready=%b expected 1", in_ready);
        end
      end
    end
    drain();
  endtask

  task automatic test_wrap();
    int sent;
    int cycles;
    sent   = 0;
    cycles = 0;
    while (sent < 20 && cycles < 400) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      gv        = rand_legal();
      out_ready = $urandom_range(0, 1);
      total++;
      if ({in_ready, out_valid, out_a, out_b, out_err} !== {model_ready(), exp_head()}) begin
        bad++;
        $display("[TB] FAIL wrap_c%0d: got %b expected %b", cycles,
                 {in_ready, out_valid, out_a, out_b, out_err}, {model_ready(), exp_head()});
      end
      if (in_valid && model_ready()) sent++;
      tick();
      cycles++;
    end
    total++;
    if (sent != 20) begin
      bad++;
      $display("[TB] FAIL wrap_budget: sent=%0d expected 20", sent);
    end
    drain();
  endtask

  task automatic test_random_mixed();
    for (int i = 0; i < 80; i++) begin
      in_valid  = $urandom_range(0, 1);
      gv        = $urandom_range(0, 1) ? rand_legal() : 7'($urandom_range(0, 127));
      out_ready = $urandom_range(0, 1);
      clr       = ($urandom_range(0, 7) == 0);
      total++;
      if ({in_ready, out_valid, out_a, out_b, out_err} !== {model_ready(), exp_head()}) begin
        bad++;
        $display("[TB] FAIL mixed_io_%0d: got %b expected %b", i,
                 {in_ready, out_valid, out_a, out_b, out_err}, {model_ready(), exp_head()});
      end
      total++;
      if ({err_cnt, err_sticky, halted} !== {8'(m_cnt), m_sticky, m_halted}) begin
        bad++;
        $display("[TB] FAIL mixed_err_%0d: cnt=%0d sticky=%b halted=%b expected %0d/%b/%b", i,
                 err_cnt, err_sticky, halted, m_cnt, m_sticky, m_halted);
      end
      tick();
    end
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    drain();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    out_ready   = 1'b0;
    s_in_valid  = 1'b1;
    s_gv        = 7'h00;
    s_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      total++;
      if (s_err_cnt !== 2'(exp_cnt) || s_halted !== 1'b0 || s_in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL sat_%0d: cnt=%0d halted=%b in_ready=%b expected %0d/0/1", i,
                 s_err_cnt, s_halted, s_in_ready, exp_cnt);
      end
      total++;
      if ({s_out_valid, s_out_err, s_err_sticky} !== 3'b111) begin
        bad++;
        $display("[TB] FAIL sat_head_%0d: got %b expected 111", i,
                 {s_out_valid, s_out_err, s_err_sticky});
      end
    end
    s_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    gv        = 7'h4D; tick();
    gv        = 7'h5A; tick();
    gv        = 7'h00; tick();
    in_valid  = 1'b0;
    total++;
    if (out_valid !== 1'b1 || err_cnt !== 8'd1 || q.size() != 3) begin
      bad++;
      $display("[TB] FAIL rmid_pre: out_valid=%b cnt=%0d expected 1/1", out_valid, err_cnt);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready, err_cnt, halted, err_sticky} !== {1'b0, 1'b1, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL rmid_async: out_valid=%b in_ready=%b cnt=%0d halted=%b expected 0/1/0/0",
               out_valid, in_ready, err_cnt, halted);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL rmid_after: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    legal = '{7'h4D, 7'h5A, 7'h1A, 7'h31};
    model_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    gv          = 7'h00;
    out_ready   = 1'b0;
    clr         = 1'b0;
    s_in_valid  = 1'b0;
    s_gv        = 7'h00;
    s_out_ready = 1'b0;
    s_clr       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_legal_sweep();
    test_illegal_halt();
    test_backpressure();
    test_wrap();
    test_random_mixed();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
